// File: rtl/booth_seq_ctrl_if.sv
// Control/status bundle between the Booth sequencer and its shift-register datapath.
// Optional abort/aborted signals exist only when BOOTH_ABORT_EN is defined.
interface booth_seq_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             q0;
    logic             q_m1;
    logic             m_load;
    logic             q_load;
    logic             a_clear;
    logic             qm1_clear;
    logic             a_load;
    logic             sub;
    logic             shift_en;
    logic             out_sel_a;
    logic             out_sel_q;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter;
`ifdef BOOTH_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    // Requester/datapath side
    modport master (
        output start, q0, q_m1,
`ifdef BOOTH_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  m_load, q_load, a_clear, qm1_clear, a_load, sub, shift_en,
               out_sel_a, out_sel_q, busy, done, iter
    );

    // Sequencer side
    modport slave (
        input  start, q0, q_m1,
`ifdef BOOTH_ABORT_EN
        input  abort,
        output aborted,
`endif
        output m_load, q_load, a_clear, qm1_clear, a_load, sub, shift_en,
               out_sel_a, out_sel_q, busy, done, iter
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Moore control FSM for radix-2 Booth signed multiplication (WIDTH iterations).
// Define BOOTH_ABORT_EN to add the abort input and aborted pulse output.
module booth_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    booth_seq_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, LOAD_M, LOAD_Q, EVAL, ADD, SUB, SHIFT, OUT_A, OUT_Q, DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] iter, iter_nxt;
`ifdef BOOTH_ABORT_EN
    logic             abort_hit;
    logic             aborted_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            iter      <= '0;
`ifdef BOOTH_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            iter      <= iter_nxt;
`ifdef BOOTH_ABORT_EN
            aborted_q <= abort_hit;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
`ifdef BOOTH_ABORT_EN
        abort_hit = 1'b0;
`endif
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD_M;
            LOAD_M:  state_nxt = LOAD_Q;
            LOAD_Q: begin
                iter_nxt  = '0;
                state_nxt = EVAL;
            end
            EVAL: begin
                case ({bus.q0, bus.q_m1})
                    2'b10:   state_nxt = SUB;
                    2'b01:   state_nxt = ADD;
                    default: state_nxt = SHIFT;
                endcase
            end
            ADD:     state_nxt = SHIFT;
            SUB:     state_nxt = SHIFT;
            SHIFT: begin
                if (iter == LAST_ITER) begin
                    state_nxt = OUT_A;
                end else begin
                    iter_nxt  = iter + 1'b1;
                    state_nxt = EVAL;
                end
            end
            OUT_A:   state_nxt = OUT_Q;
            OUT_Q:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef BOOTH_ABORT_EN
        // Abort overrides normal sequencing; DONE is allowed to complete.
        if (bus.abort && (state != IDLE) && (state != DONE)) begin
            abort_hit = 1'b1;
            state_nxt = IDLE;
            iter_nxt  = '0;
        end
`endif
    end

    always_comb begin
        bus.m_load    = 1'b0;
        bus.q_load    = 1'b0;
        bus.a_clear   = 1'b0;
        bus.qm1_clear = 1'b0;
        bus.a_load    = 1'b0;
        bus.sub       = 1'b0;
        bus.shift_en  = 1'b0;
        bus.out_sel_a = 1'b0;
        bus.out_sel_q = 1'b0;
        bus.done      = 1'b0;
        case (state)
            LOAD_M:  bus.m_load = 1'b1;
            LOAD_Q: begin
                bus.q_load    = 1'b1;
                bus.a_clear   = 1'b1;
                bus.qm1_clear = 1'b1;
            end
            ADD:     bus.a_load = 1'b1;
            SUB: begin
                bus.a_load = 1'b1;
                bus.sub    = 1'b1;
            end
            SHIFT:   bus.shift_en  = 1'b1;
            OUT_A:   bus.out_sel_a = 1'b1;
            OUT_Q:   bus.out_sel_q = 1'b1;
            DONE:    bus.done      = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.iter = iter;
`ifdef BOOTH_ABORT_EN
    assign bus.aborted = aborted_q;
`endif
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl with a behavioural A/Q/M/Q[-1] datapath model.
// Abort scenario is exercised only when BOOTH_ABORT_EN is defined.
module tb_booth_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_seq_ctrl_if #(.CNT_W(3)) bus ();
    booth_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Datapath model: inbus supplies op_m / op_q when the matching load fires.
    logic [7:0] A = '0, Q = '0, M = '0;
    logic       qm1 = 1'b0;
    logic [7:0] op_q, op_m;
    assign bus.q0   = Q[0];
    assign bus.q_m1 = qm1;

    always @(posedge clk) begin
        if (bus.m_load)    M <= op_m;
        if (bus.q_load)    Q <= op_q;
        if (bus.a_clear)   A <= '0;
        if (bus.qm1_clear) qm1 <= 1'b0;
        if (bus.a_load)    A <= bus.sub ? (A - M) : (A + M);
        if (bus.shift_en)  {A, Q, qm1} <= {A[7], A, Q};
    end

    // Per-operation activity monitor
    int         n_aload, n_shift, n_grp_err;
    logic [7:0] sub_mask, add_mask, cap_a, cap_q;
    always @(negedge clk) begin
        int grp;
        grp = int'(bus.m_load) + int'(bus.q_load | bus.a_clear | bus.qm1_clear)
            + int'(bus.a_load) + int'(bus.shift_en) + int'(bus.out_sel_a)
            + int'(bus.out_sel_q) + int'(bus.done);
        if (grp > 1 || (bus.sub && !bus.a_load)) n_grp_err++;
        if (bus.a_load) begin
            n_aload++;
            if (bus.sub) sub_mask[bus.iter] = 1'b1;
            else         add_mask[bus.iter] = 1'b1;
        end
        if (bus.shift_en)  n_shift++;
        if (bus.out_sel_a) cap_a = A;
        if (bus.out_sel_q) cap_q = Q;
    end

    task automatic clear_mon();
        n_aload = 0; n_shift = 0; n_grp_err = 0;
        sub_mask = '0; add_mask = '0; cap_a = '0; cap_q = '0;
    endtask

    function automatic logic [10:0] outs();
        return {bus.m_load, bus.q_load, bus.a_clear, bus.qm1_clear, bus.a_load, bus.sub,
                bus.shift_en, bus.out_sel_a, bus.out_sel_q, bus.busy, bus.done};
    endfunction

    // Returns the cycle index (LOAD_M = 1) on which done is observed.
    task automatic run_op(input logic [7:0] qv, input logic [7:0] mv, output int cyc);
        @(negedge clk);
        op_q = qv; op_m = mv;
        clear_mon();
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
`ifdef BOOTH_ABORT_EN
        bus.abort = 1'b0;
`endif
        #1;
        n_checks++;
        if (outs() !== 11'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", outs(), 11'h0);
        end
        n_checks++;
        if (bus.iter !== 3'd0) begin
            n_fail++; $display("FAIL reset_iter: got %0d expected 0", bus.iter);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_start: busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_sub_add();
        int cyc;
        run_op(8'h03, 8'hFB, cyc);
        n_checks++;
        if (cyc !== 23) begin n_fail++; $display("FAIL q3_latency: got %0d expected 23", cyc); end
        n_checks++;
        if (sub_mask !== 8'h01 || add_mask !== 8'h04) begin
            n_fail++; $display("FAIL q3_ops: sub %h add %h expected sub 01 add 04", sub_mask, add_mask);
        end
        n_checks++;
        if (n_shift !== 8) begin n_fail++; $display("FAIL q3_shifts: got %0d expected 8", n_shift); end
        n_checks++;
        if ({cap_a, cap_q} !== 16'hFFF1) begin
            n_fail++; $display("FAIL q3_product: got %h expected fff1", {cap_a, cap_q});
        end
        n_checks++;
        if (n_grp_err !== 0) begin n_fail++; $display("FAIL q3_onehot: got %0d expected 0", n_grp_err); end
    endtask

    task automatic test_zero();
        int cyc;
        run_op(8'h00, 8'h7F, cyc);
        n_checks++;
        if (cyc !== 21) begin n_fail++; $display("FAIL zero_latency: got %0d expected 21", cyc); end
        n_checks++;
        if (n_aload !== 0) begin n_fail++; $display("FAIL zero_aload: got %0d expected 0", n_aload); end
        n_checks++;
        if (n_shift !== 8) begin n_fail++; $display("FAIL zero_shifts: got %0d expected 8", n_shift); end
        n_checks++;
        if ({cap_a, cap_q} !== 16'h0000) begin
            n_fail++; $display("FAIL zero_product: got %h expected 0000", {cap_a, cap_q});
        end
    endtask

    task automatic test_alternating();
        int cyc;
        run_op(8'hAA, 8'h03, cyc);
        n_checks++;
        if (cyc !== 28) begin n_fail++; $display("FAIL aa_latency: got %0d expected 28", cyc); end
        n_checks++;
        if (sub_mask !== 8'hAA || add_mask !== 8'h54) begin
            n_fail++; $display("FAIL aa_ops: sub %h add %h expected sub aa add 54", sub_mask, add_mask);
        end
        n_checks++;
        if ({cap_a, cap_q} !== 16'hFEFE) begin
            n_fail++; $display("FAIL aa_product: got %h expected fefe", {cap_a, cap_q});
        end
        n_checks++;
        if (n_grp_err !== 0) begin n_fail++; $display("FAIL aa_onehot: got %0d expected 0", n_grp_err); end
    endtask

    task automatic test_back_to_back();
        int nd, nm, d1, d2, m2, m3, n_idle, w;
        nd = 0; nm = 0; d1 = 0; d2 = 0; m2 = 0; m3 = 0; n_idle = 0;
        @(negedge clk);
        op_q = 8'h03; op_m = 8'hFB;
        bus.start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (nd == 1) d1 = c; else if (nd == 2) d2 = c;
            end
            if (bus.m_load) begin
                nm++;
                if (nm == 2) m2 = c; else if (nm == 3) m3 = c;
            end
            if (!bus.busy) n_idle++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
        n_checks++;
        if (d1 !== 23 || d2 !== 47) begin
            n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 23,47", d1, d2);
        end
        n_checks++;
        if (nm !== 3 || m2 !== 25 || m3 !== 49) begin
            n_fail++; $display("FAIL b2b_restart: loads %0d at %0d,%0d expected 3 at 25,49", nm, m2, m3);
        end
        n_checks++;
        if (n_idle !== 2) begin n_fail++; $display("FAIL b2b_idle_cycles: got %0d expected 2", n_idle); end
        w = 0;
        while (!bus.done && w < 40) begin @(negedge clk); w++; end
        n_checks++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_third_done: got %b expected 1", bus.done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w, nd, cyc;
        @(negedge clk);
        op_q = 8'hAA; op_m = 8'h03;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (!(bus.shift_en && bus.iter == 3'd4) && w < 60) begin @(negedge clk); w++; end
        n_checks++;
        if (!(bus.shift_en === 1'b1 && bus.iter === 3'd4)) begin
            n_fail++; $display("FAIL rst_reach_shift4: shift %b iter %0d expected 1 and 4", bus.shift_en, bus.iter);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 11'h0 || bus.iter !== 3'd0) begin
            n_fail++; $display("FAIL rst_async_clear: outs %h iter %0d expected 000 and 0", outs(), bus.iter);
        end
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL rst_no_done: active cycles %0d expected 0", nd); end
        run_op(8'h00, 8'h7F, cyc);
        n_checks++;
        if (cyc !== 21 || {cap_a, cap_q} !== 16'h0000) begin
            n_fail++; $display("FAIL rst_fresh_op: cyc %0d prod %h expected 21 and 0000", cyc, {cap_a, cap_q});
        end
    endtask

`ifdef BOOTH_ABORT_EN
    task automatic test_abort();
        int w;
        @(negedge clk);
        op_q = 8'h03; op_m = 8'hFB;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (!(bus.a_load && !bus.sub) && w < 60) begin @(negedge clk); w++; end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b1 || bus.done !== 1'b0 || bus.iter !== 3'd0) begin
            n_fail++; $display("FAIL abort_state: busy %b aborted %b done %b iter %0d expected 0 1 0 0",
                               bus.busy, bus.aborted, bus.done, bus.iter);
        end
        @(negedge clk);
        n_checks++;
        if (bus.aborted !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL abort_pulse: aborted %b done %b expected 0 0", bus.aborted, bus.done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sub_add();
        test_zero();
        test_alternating();
        test_back_to_back();
        test_reset_mid();
`ifdef BOOTH_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
